// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request path (pending latch and priority encoder).
package irq_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = $clog2(N_REQ);

    typedef logic [N_REQ-1:0] req_vec_t;
endpackage

// File: rtl/irq_sync_edge.sv
// Per-line request synchroniser (two flops when IRQ_SYNC_EN is defined) and rising-edge detector.
// Without IRQ_SYNC_EN the request is assumed already synchronous to clk.
module irq_sync_edge
    import irq_pkg::*;
#(
    parameter int W = irq_pkg::N_REQ
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_req,
    output logic [W-1:0] o_edge
);

    logic [W-1:0] w_s;
    logic [W-1:0] r_prev;

`ifdef IRQ_SYNC_EN
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_req;
            r_sync <= r_meta;
        end
    end

    assign w_s = r_sync;
`else
    assign w_s = i_req;
`endif

    // prev tracks regardless of enable so a level held across enable rising is not an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_s;
        end
    end

    assign o_edge = w_s & ~r_prev;

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky, maskable pending/overrun latch feeding the priority encoder; cleared by indexed ack.
// Optional build macro IRQ_SYNC_EN adds a two-flop request synchroniser (3-cycle capture latency).
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int N_REQ = irq_pkg::N_REQ,
    parameter int IDX_W = irq_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_REQ-1:0] req_in,
    input  logic             mask_wr,
    input  logic [N_REQ-1:0] mask_data,
    input  logic             ack_valid,
    input  logic [IDX_W-1:0] ack_idx,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] raw_pending,
    output logic [N_REQ-1:0] overrun,
    output logic             irq
);

    logic [N_REQ-1:0] w_edge;
    logic [N_REQ-1:0] w_ack_hit;
    logic [N_REQ-1:0] w_raw_next;
    logic [N_REQ-1:0] w_ovr_next;
    logic [N_REQ-1:0] w_mask_next;
    logic [N_REQ-1:0] w_pend_next;

    logic [N_REQ-1:0] r_raw;
    logic [N_REQ-1:0] r_ovr;
    logic [N_REQ-1:0] r_mask;
    logic [N_REQ-1:0] r_pend;
    logic             r_irq;

    irq_sync_edge #(
        .W(N_REQ)
    ) u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (req_in),
        .o_edge(w_edge)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_line
            logic w_cap;

            // out-of-range indices never match any line, so they are ignored
            assign w_ack_hit[gi]  = ack_valid && (int'(ack_idx) == gi);
            assign w_cap          = ena & w_edge[gi];
            // set beats clear; overrun drops on ack since the acked event was serviced
            assign w_raw_next[gi] = w_cap | (r_raw[gi] & ~w_ack_hit[gi]);
            assign w_ovr_next[gi] = ~w_ack_hit[gi] & (r_ovr[gi] | (w_cap & r_raw[gi]));
        end
    endgenerate

    assign w_mask_next = mask_wr ? mask_data : r_mask;
    assign w_pend_next = w_raw_next & w_mask_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_raw  <= '0;
            r_ovr  <= '0;
            r_mask <= '1;
            r_pend <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_raw  <= w_raw_next;
            r_ovr  <= w_ovr_next;
            r_mask <= w_mask_next;
            r_pend <= w_pend_next;
            r_irq  <= |w_pend_next;
        end
    end

    assign pending     = r_pend;
    assign raw_pending = r_raw;
    assign overrun     = r_ovr;
    assign irq         = r_irq;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed self-checking bench for irq_pending_latch; capture latency follows IRQ_SYNC_EN.
module tb_irq_pending_latch;
    import irq_pkg::*;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic [N_REQ-1:0] req_in;
    logic             mask_wr;
    logic [N_REQ-1:0] mask_data;
    logic             ack_valid;
    logic [IDX_W-1:0] ack_idx;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] raw_pending;
    logic [N_REQ-1:0] overrun;
    logic             irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irq_pending_latch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_in     (req_in),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .ack_valid  (ack_valid),
        .ack_idx    (ack_idx),
        .pending    (pending),
        .raw_pending(raw_pending),
        .overrun    (overrun),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack(input int idx);
        ack_valid = 1'b1;
        ack_idx   = IDX_W'(idx);
        tick(1);
        ack_valid = 1'b0;
    endtask

    task automatic write_mask(input logic [N_REQ-1:0] m);
        mask_wr   = 1'b1;
        mask_data = m;
        tick(1);
        mask_wr   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        req_in    = '0;
        mask_wr   = 1'b0;
        mask_data = '0;
        ack_valid = 1'b0;
        ack_idx   = '0;

        // reset
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("rst_raw", 32'(raw_pending), 32'h00);
        check("rst_pend", 32'(pending), 32'h00);
        check("rst_ovr", 32'(overrun), 32'h00);
        check("rst_irq", 32'(irq), 32'h0);

        // single capture, exact latency, then ack
        req_in = 8'h20;
        tick(LAT - 1);
        check("cap_early", 32'(pending), 32'h00);
        tick(1);
        check("cap_pend", 32'(pending), 32'h20);
        check("cap_irq", 32'(irq), 32'h1);
        ack(5);
        check("ack_pend", 32'(pending), 32'h00);
        check("ack_irq", 32'(irq), 32'h0);
        tick(3);
        check("held_no_recap", 32'(raw_pending), 32'h00);
        req_in = '0;
        tick(3);

        // overrun on bit 2
        req_in = 8'h04; tick(3);
        req_in = 8'h00; tick(3);
        check("ovr_first", 32'(overrun), 32'h00);
        req_in = 8'h04; tick(3);
        check("ovr_set", 32'(overrun), 32'h04);
        check("ovr_raw", 32'(raw_pending), 32'h04);
        ack(2);
        check("ovr_ack_raw", 32'(raw_pending), 32'h00);
        check("ovr_ack_ovr", 32'(overrun), 32'h00);
        req_in = '0; tick(3);

        // ack/edge collision on bit 3 while bit 3 is already pending
        req_in = 8'h08; tick(3);
        req_in = 8'h00; tick(3);
        req_in = 8'h08;
        tick(LAT - 1);
        ack(3);
        check("coll_raw", 32'(raw_pending), 32'h08);
        check("coll_ovr", 32'(overrun), 32'h00);
        ack(3);
        check("coll_clear", 32'(raw_pending), 32'h00);
        req_in = '0; tick(3);

        // masking
        write_mask(8'h0F);
        req_in = 8'hF0;
        tick(LAT + 1);
        check("mask_raw", 32'(raw_pending), 32'hF0);
        check("mask_pend", 32'(pending), 32'h00);
        check("mask_irq", 32'(irq), 32'h0);
        write_mask(8'hFF);
        check("unmask_pend", 32'(pending), 32'hF0);
        check("unmask_irq", 32'(irq), 32'h1);
        for (int i = 4; i < 8; i++) ack(i);
        check("mask_cleared", 32'(raw_pending), 32'h00);
        req_in = '0; tick(3);

        // enable gating
        ena = 1'b0;
        req_in = 8'h01;
        tick(4);
        check("ena_off", 32'(raw_pending), 32'h00);
        ena = 1'b1;
        tick(3);
        check("ena_level", 32'(raw_pending), 32'h00);
        req_in = 8'h00; tick(3);
        req_in = 8'h01; tick(LAT);
        check("ena_fresh_raw", 32'(raw_pending), 32'h01);
        check("ena_fresh_pend", 32'(pending), 32'h01);

        // ack of a bit that is not pending
        ack(6);
        check("ack_idle", 32'(raw_pending), 32'h01);

        // reset mid-operation with the line held high
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_raw", 32'(raw_pending), 32'h00);
        check("mid_rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        tick(LAT);
        check("post_rst_cap", 32'(raw_pending), 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Request-capture stage directly upstream of `tt_um_priority_encoder`. It turns eight level request lines into sticky, maskable pending bits and presents the masked vector for encoding. It clears a bit only when the consumer acknowledges the encoded index. It flags overruns, meaning a new rising edge on a line whose previous event is still pending.

## Interface
Parameters:
- `N_REQ`, 8: number of request lines; must equal the encoder input width.
- `IDX_W`, 3: index width, equal to $clog2(N_REQ).

Clock, reset and enable (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `ena`  in  1  design enable; low blocks new captures.

Request and configuration:
- `req_in`  in  N_REQ  asynchronous level request lines.
- `mask_wr`  in  1  one-cycle strobe to load `mask_data`.
- `mask_data`  in  N_REQ  new enable mask; 1 = line enabled.

Acknowledge:
- `ack_valid`  in  1  one-cycle strobe: the consumer has serviced `ack_idx`.
- `ack_idx`  in  IDX_W  index being acknowledged.

Outputs (all registered):
- `pending`  out  N_REQ  raw_pending & mask; feeds the priority encoder.
- `raw_pending`  out  N_REQ  unmasked sticky pending bits.
- `overrun`  out  N_REQ  sticky per-line overrun flags.
- `irq`  out  1  OR-reduce of `pending`.

## Operation
- Edge detect per line: `edge[i] = s[i] & ~prev[i]`.
  - `s` is the synchronised request (see Configuration).
  - `prev` is `s` delayed one cycle; `prev` updates every cycle regardless of `ena`.
- Capture: if `ena` is high and `edge[i]` is high, set `raw_pending[i]`. If `raw_pending[i]` was already 1, also set `overrun[i]`.
- Acknowledge: if `ack_valid` is high, clear `raw_pending[ack_idx]` and `overrun[ack_idx]`.
  - Ack of a bit that is not pending: no effect.
  - `ack_idx >= N_REQ`: ignored.
- Same bit, same cycle, edge and ack: set wins. The bit stays pending. `overrun` is cleared, because the acked event was serviced and the new one is not lost.
- Mask:
  - `mask_wr` loads `mask` in one cycle.
  - Masked lines still capture into `raw_pending` but are hidden from `pending` and `irq`.
  - Unmasking a line with a raw pending bit exposes it on the next cycle.
- `ena` low:
  - No new captures and no overrun updates.
  - Ack and mask writes still function.
  - Because `prev` keeps tracking, a level already high when `ena` rises produces no spurious edge.
- Reset values: `raw_pending`=0, `overrun`=0, `pending`=0, `irq`=0, `mask`='1 (all enabled), sync/prev flops=0.
  - Reset mid-operation discards all pending and overrun state.
  - A line held high through reset release produces an edge after release. Its `prev` starts at 0, so the edge is captured (intentional: the level counts as a new request).

## Timing
- Synchroniser compiled in: `req_in` rising before edge N → `raw_pending`/`pending`/`irq` high after edge N+2 (3-cycle latency).
- Synchroniser compiled out: visible after edge N (1-cycle latency).
- Ack: `ack_valid` sampled at edge M → bit clear after edge M.
- Consumer contract: `pending` → encoder is combinational, so the consumer may ack the encoded index in the same cycle it observes it.
- Mask write at edge M → `pending` reflects the new mask after edge M.
- Request pulses shorter than one clock period may be missed; this is not a supported use.

## Configuration
- `IRQ_SYNC_EN` defined:
  - Two-flop synchroniser on each `req_in` bit; `s` = second flop.
  - Capture latency 3 cycles.
- `IRQ_SYNC_EN` not defined:
  - `s = req_in` directly; capture latency 1 cycle.
  - For benches and for inputs already synchronous to `clk`.

## Structure
- Shared package `irq_pkg`: `N_REQ`, `IDX_W` defaults, and the `req_vec_t` typedef (`logic [N_REQ-1:0]`). The encoder shares this package.
- One sub-module, `irq_sync_edge`: per-vector synchroniser (gated by `IRQ_SYNC_EN`) plus the `prev` flop, outputting `edge`.
- The top of this block holds the pending, overrun and mask registers and the ack decode.

## Test plan
- Reset: `rst_n`=0 for 2 cycles, then 1 → all outputs 0; `mask`=8'hFF; no capture while `req_in`=0.
- Single capture: `req_in`=8'h20 held → `pending`=8'h20 and `irq`=1 exactly 3 cycles later (1 cycle without the macro). `ack_idx`=5 with `ack_valid` → `pending`=0.
- Overrun: `req_in[2]` pulses 0→1→0→1, with ≥3 cycles per level, without ack → `overrun`=8'h04. `ack_idx`=2 → `raw_pending`=0, `overrun`=0.
- Ack/edge collision: edge on bit 3 lands in the same cycle as `ack_idx`=3 → `raw_pending[3]`=1, `overrun[3]`=0.
- Masking: `mask_data`=8'h0F; `req_in`=8'hF0 → `raw_pending`=8'hF0, `pending`=0, `irq`=0. `mask_data`=8'hFF → `pending`=8'hF0 next cycle.
- Enable gating: `ena`=0, `req_in` 0→8'h01 → no capture. `ena`=1 with line still high → still no capture. A fresh 0→1 on bit 0 → captured.
